car_fcw_sched: RTL and testbench

- Sequencer for the carrier NCO frequency control word (FCW) in the BD3 receiver.
- During acquisition, steps the FCW through a Doppler bin grid in zig-zag order: centre, +1, -1, +2, -2, …
- Drives a dwell per bin, hands the bin to the correlator, and waits for its detect verdict.
- On detection, switches to tracking, where the carrier loop applies FCW corrections. Output feeds the NCO FCW input directly.

---
 rtl/car_sched_pkg.sv | 18 +
 rtl/car_bin_seq.sv | 72 +++++++
 rtl/car_fcw_sched.sv | 173 +++++++++++++++++
 tb/tb_car_fcw_sched.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/car_sched_pkg.sv
// Carrier FCW scheduler package: state encodings and default widths.
// Shared by car_fcw_sched (top) and car_bin_seq (zig-zag bin sequencer).
package car_sched_pkg;

  localparam int unsigned FCW_W_DEF   = 32;
  localparam int unsigned BIN_W_DEF   = 6;
  localparam int unsigned DWELL_W_DEF = 16;
  localparam int unsigned TMO_W_DEF   = 12;

  // Values are visible on tx_state.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_WAIT  = 2'd2,
    ST_TRACK = 2'd3
  } car_state_e;

endpackage

// File: rtl/car_bin_seq.sv
// Zig-zag Doppler bin sequencer: centre, +1, -1, +2, -2, ...
// Two accumulators walk outward from the centre FCW, modulo 2^FCW_W.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   load_i       restart at bin 0 from ctr_i
//   adv_i        step to the next ordinal
//   ctr_i        centre FCW (sampled on load_i)
//   step_i       bin spacing (used on adv_i)
//   bin_num_i    N, bins per side
//   fcw_o        FCW of the bin being entered this cycle (valid with load_i/adv_i)
//   idx_o        current bin ordinal 0..2N
//   last_o       current ordinal is the last of the grid (2N)
module car_bin_seq
  import car_sched_pkg::*;
#(
  parameter int unsigned FCW_W = FCW_W_DEF,
  parameter int unsigned BIN_W = BIN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             adv_i,
  input  logic [FCW_W-1:0] ctr_i,
  input  logic [FCW_W-1:0] step_i,
  input  logic [BIN_W-1:0] bin_num_i,
  output logic [FCW_W-1:0] fcw_o,
  output logic [BIN_W:0]   idx_o,
  output logic             last_o
);

  logic [FCW_W-1:0] pos_q, pos_d, neg_q, neg_d;
  logic [BIN_W:0]   idx_q, idx_d;

  always_comb begin
    pos_d = pos_q;
    neg_d = neg_q;
    idx_d = idx_q;
    fcw_o = ctr_i;
    if (load_i) begin
      pos_d = ctr_i;
      neg_d = ctr_i;
      idx_d = '0;
      fcw_o = ctr_i;
    end else if (adv_i) begin
      idx_d = idx_q + 1'b1;
      // Odd ordinals go above centre, even ordinals below.
      if (idx_d[0]) begin
        pos_d = pos_q + step_i;
        fcw_o = pos_d;
      end else begin
        neg_d = neg_q - step_i;
        fcw_o = neg_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q <= '0;
      neg_q <= '0;
      idx_q <= '0;
    end else begin
      pos_q <= pos_d;
      neg_q <= neg_d;
      idx_q <= idx_d;
    end
  end

  assign idx_o  = idx_q;
  assign last_o = (idx_q == {bin_num_i, 1'b0});

endmodule

// File: rtl/car_fcw_sched.sv
// Carrier NCO FCW scheduler: zig-zag acquisition over a Doppler bin grid,
// then tracking with FCW corrections from the carrier loop.
// Optional feature macro CAR_SCHED_TMO_EN: detect-wait timeout (2^TMO_W-1
// cycles without a verdict counts as a negative verdict).
// Ports:
//   rx_clk, rx_rst_n        clock, async active-low reset
//   rx_start / rx_abort     begin search (IDLE only) / return to IDLE
//   rx_cfg_*                centre FCW, bin step, N, dwell (shadowed at start)
//   rx_det_vld, rx_det      correlator verdict (WAIT only)
//   rx_trk_vld, rx_trk_dfcw signed FCW correction (TRACK only)
//   rx_unlock               loss of lock: restart search from bin 0
//   tx_car_fcw              FCW to NCO
//   tx_nco_rst, tx_corr_clr bin-start pulses
//   tx_dump                 end-of-dwell pulse
//   tx_bin_idx, tx_state    bin ordinal, state code
//   tx_busy, tx_lock        DWELL/WAIT, TRACK
//   tx_fail                 sticky grid-exhausted flag
module car_fcw_sched
  import car_sched_pkg::*;
#(
  parameter int unsigned FCW_W   = FCW_W_DEF,
  parameter int unsigned BIN_W   = BIN_W_DEF,
  parameter int unsigned DWELL_W = DWELL_W_DEF,
  parameter int unsigned TMO_W   = TMO_W_DEF
) (
  input  logic               rx_clk,
  input  logic               rx_rst_n,
  input  logic               rx_start,
  input  logic               rx_abort,
  input  logic [FCW_W-1:0]   rx_cfg_fcw_ctr,
  input  logic [FCW_W-1:0]   rx_cfg_fcw_step,
  input  logic [BIN_W-1:0]   rx_cfg_bin_num,
  input  logic [DWELL_W-1:0] rx_cfg_dwell,
  input  logic               rx_det_vld,
  input  logic               rx_det,
  input  logic               rx_trk_vld,
  input  logic [FCW_W-1:0]   rx_trk_dfcw,
  input  logic               rx_unlock,
  output logic [FCW_W-1:0]   tx_car_fcw,
  output logic               tx_nco_rst,
  output logic               tx_corr_clr,
  output logic               tx_dump,
  output logic [BIN_W:0]     tx_bin_idx,
  output logic [1:0]         tx_state,
  output logic               tx_busy,
  output logic               tx_lock,
  output logic               tx_fail
);

  car_state_e         state_q;
  logic [FCW_W-1:0]   fcw_q, ctr_sh_q, step_sh_q;
  logic [BIN_W-1:0]   bin_sh_q;
  logic [DWELL_W-1:0] dwell_sh_q, dcnt_q;
  logic               nco_rst_q, dump_q, fail_q;

  logic               start_go, unlock_go, verdict, det_pos;
  logic               adv_go, fail_go, trk_go, seq_load, enter_bin, tmo_hit;
  logic [FCW_W-1:0]   ctr_ld, seq_fcw;
  logic [DWELL_W-1:0] dwell_src, dwell_m1;
  logic               seq_last;

`ifdef CAR_SCHED_TMO_EN
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((1 << TMO_W) - 2);
  logic [TMO_W-1:0] tmo_q;

  // tmo_q counts WAIT cycles from 0; firing on count 2^TMO_W-2 means the
  // bin gives up after 2^TMO_W-1 silent WAIT cycles.
  assign tmo_hit = (state_q == ST_WAIT) && !rx_det_vld && (tmo_q == TMO_LAST);

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n)                                   tmo_q <= '0;
    else if (state_q == ST_WAIT && !rx_det_vld && !rx_abort) tmo_q <= tmo_q + 1'b1;
    else                                             tmo_q <= '0;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    start_go  = (state_q == ST_IDLE)  && rx_start  && !rx_abort;
    unlock_go = (state_q == ST_TRACK) && rx_unlock && !rx_abort;
    verdict   = (state_q == ST_WAIT)  && !rx_abort && (rx_det_vld || tmo_hit);
    det_pos   = rx_det_vld && rx_det;
    adv_go    = verdict && !det_pos && !seq_last;
    fail_go   = verdict && !det_pos &&  seq_last;
    trk_go    = verdict &&  det_pos;
    seq_load  = start_go || unlock_go;
    enter_bin = seq_load || adv_go;
    // A start uses live config (shadows load the same edge); restarts use shadows.
    ctr_ld    = start_go ? rx_cfg_fcw_ctr : ctr_sh_q;
    dwell_src = start_go ? rx_cfg_dwell   : dwell_sh_q;
    dwell_m1  = (dwell_src == '0) ? '0 : dwell_src - 1'b1;
  end

  car_bin_seq #(
    .FCW_W (FCW_W),
    .BIN_W (BIN_W)
  ) u_bin_seq (
    .clk       (rx_clk),
    .rst_n     (rx_rst_n),
    .load_i    (seq_load),
    .adv_i     (adv_go),
    .ctr_i     (ctr_ld),
    .step_i    (step_sh_q),
    .bin_num_i (bin_sh_q),
    .fcw_o     (seq_fcw),
    .idx_o     (tx_bin_idx),
    .last_o    (seq_last)
  );

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      state_q    <= ST_IDLE;
      fcw_q      <= '0;
      ctr_sh_q   <= '0;
      step_sh_q  <= '0;
      bin_sh_q   <= '0;
      dwell_sh_q <= '0;
      dcnt_q     <= '0;
      nco_rst_q  <= 1'b0;
      dump_q     <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      nco_rst_q <= 1'b0;
      dump_q    <= 1'b0;
      if (start_go) begin
        ctr_sh_q   <= rx_cfg_fcw_ctr;
        step_sh_q  <= rx_cfg_fcw_step;
        bin_sh_q   <= rx_cfg_bin_num;
        dwell_sh_q <= rx_cfg_dwell;
      end
      if (rx_abort) begin
        state_q <= ST_IDLE;
      end else if (enter_bin) begin
        state_q   <= ST_DWELL;
        fcw_q     <= seq_fcw;
        nco_rst_q <= 1'b1;
        // dcnt_q holds cycles remaining after the current one.
        dcnt_q    <= dwell_m1;
        dump_q    <= (dwell_m1 == '0);
        if (seq_load) fail_q <= 1'b0;
      end else if (fail_go) begin
        fail_q  <= 1'b1;
        state_q <= ST_IDLE;
      end else if (trk_go) begin
        state_q <= ST_TRACK;
      end else begin
        case (state_q)
          ST_DWELL: begin
            if (dcnt_q == '0) begin
              state_q <= ST_WAIT;
            end else begin
              dcnt_q <= dcnt_q - 1'b1;
              dump_q <= (dcnt_q == DWELL_W'(1));
            end
          end
          ST_TRACK: if (rx_trk_vld) fcw_q <= fcw_q + rx_trk_dfcw;
          default: ;
        endcase
      end
    end
  end

  assign tx_car_fcw  = fcw_q;
  assign tx_nco_rst  = nco_rst_q;
  assign tx_corr_clr = nco_rst_q;
  assign tx_dump     = dump_q;
  assign tx_state    = state_q;
  assign tx_busy     = (state_q == ST_DWELL) || (state_q == ST_WAIT);
  assign tx_lock     = (state_q == ST_TRACK);
  assign tx_fail     = fail_q;

endmodule

// File: tb/tb_car_fcw_sched.sv
// Directed bench for car_fcw_sched (default build, timeout feature off).
module tb_car_fcw_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 0, abort = 0, det_vld = 0, det = 0, trk_vld = 0, unlock = 0;
  logic [31:0] cfg_ctr = 0, cfg_step = 0, trk_dfcw = 0;
  logic [5:0]  cfg_n = 0;
  logic [15:0] cfg_dwell = 0;
  logic [31:0] car_fcw;
  logic        nco_rst, corr_clr, dump, busy, lock, fail;
  logic [6:0]  bin_idx;
  logic [1:0]  state;

  int n_chk = 0, n_err = 0;

  car_fcw_sched dut (
    .rx_clk(clk), .rx_rst_n(rst_n), .rx_start(start), .rx_abort(abort),
    .rx_cfg_fcw_ctr(cfg_ctr), .rx_cfg_fcw_step(cfg_step),
    .rx_cfg_bin_num(cfg_n), .rx_cfg_dwell(cfg_dwell),
    .rx_det_vld(det_vld), .rx_det(det), .rx_trk_vld(trk_vld),
    .rx_trk_dfcw(trk_dfcw), .rx_unlock(unlock),
    .tx_car_fcw(car_fcw), .tx_nco_rst(nco_rst), .tx_corr_clr(corr_clr),
    .tx_dump(dump), .tx_bin_idx(bin_idx), .tx_state(state),
    .tx_busy(busy), .tx_lock(lock), .tx_fail(fail)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start();
    start = 1; tick(); start = 0;
  endtask

  task automatic verdict(input logic d);
    det_vld = 1; det = d; tick(); det_vld = 0; det = 0;
  endtask

  // Checks bin entry, measures nco_rst->dump distance, ends in WAIT.
  task automatic run_bin(input logic [31:0] efcw, input int eidx, input int edwell);
    int cnt;
    chk($sformatf("fcw%0d", eidx), car_fcw, efcw);
    chk($sformatf("idx%0d", eidx), bin_idx, eidx);
    chk("nco_rst", nco_rst, 1);
    chk("corr_clr", corr_clr, 1);
    chk("st_dwell", state, 1);
    cnt = 1;
    while (!dump && cnt < 100) begin tick(); cnt++; end
    chk("dwell_len", cnt, edwell);
    tick();
    chk("st_wait", state, 2);
    chk("busy_wait", busy, 1);
  endtask

  logic [31:0] grid [5] = '{32'h0A3D70A4, 32'h0A4D70A4, 32'h0A2D70A4,
                            32'h0A5D70A4, 32'h0A1D70A4};
  logic [31:0] wrapv [3] = '{32'hFFF00000, 32'h00100000, 32'hFFD00000};

  initial begin
    // Reset state
    #12;
    chk("rst_fcw", car_fcw, 0); chk("rst_state", state, 0);
    chk("rst_flags", {nco_rst, corr_clr, dump, busy, lock, fail}, 0);
    chk("rst_idx", bin_idx, 0);
    rst_n = 1; tick();

    // Grid walk; config changed after start must not matter
    cfg_ctr = 32'h0A3D70A4; cfg_step = 32'h00100000; cfg_n = 2; cfg_dwell = 4;
    do_start();
    cfg_ctr = 32'h11111111; cfg_step = 32'h00000001; cfg_n = 0; cfg_dwell = 9;
    for (int i = 0; i < 5; i++) begin
      run_bin(grid[i], i, 4);
      if (i == 2) begin
        // start ignored outside IDLE
        start = 1; tick(); start = 0;
        chk("start_ign", state, 2);
      end
      verdict(0);
    end
    chk("grid_fail", fail, 1); chk("grid_idle", state, 0); chk("grid_busy", busy, 0);

    // Wrap, detect on ordinal 2, track
    cfg_ctr = 32'hFFF00000; cfg_step = 32'h00200000; cfg_n = 1; cfg_dwell = 2;
    do_start();
    chk("fail_clr", fail, 0);
    for (int i = 0; i < 3; i++) begin
      run_bin(wrapv[i], i, 2);
      if (i < 2) verdict(0);
    end
    verdict(1);
    chk("trk_state", state, 3); chk("trk_lock", lock, 1); chk("trk_hold", car_fcw, 32'hFFD00000);
    tick();
    chk("trk_idle", car_fcw, 32'hFFD00000);
    trk_vld = 1; trk_dfcw = 32'h10; tick();
    chk("trk1", car_fcw, 32'hFFD00010);
    trk_dfcw = 32'hFFFFFFD0; tick();
    chk("trk2", car_fcw, 32'hFFCFFFE0);
    trk_dfcw = 32'h5; tick(); trk_vld = 0;
    chk("trk3", car_fcw, 32'hFFCFFFE5); chk("trk_lock2", lock, 1);

    // Unlock (with a simultaneous correction, which unlock overrides)
    unlock = 1; trk_vld = 1; trk_dfcw = 32'h100; tick(); unlock = 0; trk_vld = 0;
    chk("unl_lock", lock, 0);
    run_bin(32'hFFF00000, 0, 2);

    // Abort together with a positive verdict
    abort = 1; det_vld = 1; det = 1; tick(); abort = 0; det_vld = 0; det = 0;
    chk("abt_state", state, 0); chk("abt_lock", lock, 0); chk("abt_busy", busy, 0);
    chk("abt_fcw", car_fcw, 32'hFFF00000); chk("abt_fail", fail, 0);

    // Strobes ignored in IDLE; abort beats start
    trk_vld = 1; trk_dfcw = 32'h100; det_vld = 1; tick(); trk_vld = 0; det_vld = 0;
    chk("idle_trk", car_fcw, 32'hFFF00000); chk("idle_det", state, 0);
    abort = 1; start = 1; tick(); abort = 0; start = 0;
    chk("abt_start", state, 0); chk("abt_start_p", nco_rst, 0);

    // dwell=0, N=0
    cfg_ctr = 32'h12345678; cfg_n = 0; cfg_dwell = 0;
    do_start();
    chk("d0_coinc", {nco_rst, dump}, 2'b11);
    run_bin(32'h12345678, 0, 1);
    verdict(0);
    chk("n0_fail", fail, 1); chk("n0_idle", state, 0);

    // Async reset mid-dwell
    cfg_dwell = 10; cfg_n = 3;
    do_start(); tick(); tick();
    chk("pre_rst", state, 1);
    #2 rst_n = 0; #1;
    chk("arst_state", state, 0); chk("arst_fcw", car_fcw, 0);
    chk("arst_flags", {nco_rst, dump, busy, lock, fail}, 0);
    #3 rst_n = 1; tick();
    chk("arst_after", state, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
